// File: rtl/hdmi_period_sequencer.sv
// HDMI/DVI period sequencer: walks the raster and emits the period code,
// TMDS control bits, syncs and data-island packet slot timing, all registered.
module hdmi_period_sequencer #(
  parameter int H_ACTIVE     = 640,
  parameter int H_TOTAL      = 800,
  parameter int V_ACTIVE     = 480,
  parameter int V_TOTAL      = 525,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_END   = 752,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_END   = 492,
  parameter int SYNC_POL     = 0,
  parameter int DVI_OUTPUT   = 0,
  parameter int MAX_PACKETS  = 2
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic        packet_pending,
  output logic [2:0]  mode,
  output logic [3:0]  ctrl,
  output logic        hsync,
  output logic        vsync,
  output logic [15:0] cx,
  output logic [15:0] cy,
  output logic        packet_ready,
  output logic [4:0]  packet_index
);

  // The island plus the video preamble must fit inside horizontal blanking.
  generate
    if (H_ACTIVE + 20 + 32 * MAX_PACKETS > H_TOTAL - 10) begin : g_param_check
      $error("hdmi_period_sequencer: data island does not fit in horizontal blanking");
    end
  endgenerate

  localparam logic [15:0] HT_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] VT_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0] HA        = 16'(H_ACTIVE);
  localparam logic [15:0] VA        = 16'(V_ACTIVE);
  localparam logic [15:0] DECIDE_CX = 16'(H_ACTIVE + 3);
  localparam logic [15:0] PRE_CX    = 16'(H_TOTAL - 10);
  localparam logic [15:0] GUARD_CX  = 16'(H_TOTAL - 2);
  localparam logic [15:0] HS_START  = 16'(H_SYNC_START);
  localparam logic [15:0] HS_END    = 16'(H_SYNC_END);
  localparam logic [15:0] VS_START  = 16'(V_SYNC_START);
  localparam logic [15:0] VS_END    = 16'(V_SYNC_END);
  localparam logic [5:0]  MAXP      = 6'(MAX_PACKETS);
  localparam logic        SYNC_ON   = (SYNC_POL != 0);
  localparam logic        DVI       = (DVI_OUTPUT != 0);

  localparam logic [2:0] M_CTRL     = 3'd0;
  localparam logic [2:0] M_VID_PRE  = 3'd1;
  localparam logic [2:0] M_VID_GRD  = 3'd2;
  localparam logic [2:0] M_VIDEO    = 3'd3;
  localparam logic [2:0] M_DI_PRE   = 3'd4;
  localparam logic [2:0] M_DI_LEAD  = 3'd5;
  localparam logic [2:0] M_DI_PKT   = 3'd6;
  localparam logic [2:0] M_DI_TRAIL = 3'd7;

  typedef enum logic [2:0] {ISL_IDLE, ISL_PRE, ISL_GLEAD, ISL_PACKET, ISL_GTRAIL} isl_t;

  isl_t        state_reg, state_next;
  logic [4:0]  cnt_reg, cnt_next;
  logic [5:0]  slots_reg, slots_next;
  logic        armed_reg, armed_next;
  logic [15:0] cx_next, cy_next, line_after;
  logic [2:0]  mode_next;
  logic [3:0]  ctrl_next;
  logic        hsync_next, vsync_next, ready_next;
  logic [4:0]  index_next;

  // Raster position of the next cycle; all outputs are derived from it so
  // that the registered outputs agree with the registered cx/cy.
  always_comb begin
    cx_next    = (cx == HT_LAST) ? 16'd0 : cx + 16'd1;
    cy_next    = cy;
    if (cx == HT_LAST) cy_next = (cy == VT_LAST) ? 16'd0 : cy + 16'd1;
    line_after = (cy_next == VT_LAST) ? 16'd0 : cy_next + 16'd1;
    armed_next = armed_reg | ((cy_next == VT_LAST) && (cx_next == PRE_CX));
  end

  // Island phase sequencing; packet_pending is only looked at on the
  // decision cycle and on the last cycle of each packet slot.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 5'd1;
    slots_next = slots_reg;
    case (state_reg)
      ISL_IDLE: begin
        cnt_next = 5'd0;
        if ((cx == DECIDE_CX) && armed_reg && !DVI && packet_pending)
          state_next = ISL_PRE;
      end
      ISL_PRE: if (cnt_reg == 5'd7) begin
        state_next = ISL_GLEAD;
        cnt_next   = 5'd0;
      end
      ISL_GLEAD: if (cnt_reg == 5'd1) begin
        state_next = ISL_PACKET;
        cnt_next   = 5'd0;
        slots_next = 6'd1;
      end
      ISL_PACKET: if (cnt_reg == 5'd31) begin
        if (packet_pending && (slots_reg < MAXP)) begin
          slots_next = slots_reg + 6'd1;
        end else begin
          state_next = ISL_GTRAIL;
        end
        cnt_next = 5'd0;
      end
      ISL_GTRAIL: if (cnt_reg == 5'd1) begin
        state_next = ISL_IDLE;
        cnt_next   = 5'd0;
      end
      default: begin
        state_next = ISL_IDLE;
        cnt_next   = 5'd0;
      end
    endcase
  end

  // Period code, control bits, syncs and slot outputs for the next cycle.
  always_comb begin
    mode_next  = M_CTRL;
    ctrl_next  = 4'b0000;
    ready_next = 1'b0;
    index_next = 5'd0;
    if (armed_next) begin
      case (state_next)
        ISL_PRE: begin
          mode_next = M_DI_PRE;
          ctrl_next = 4'b1010;
        end
        ISL_GLEAD:  mode_next = M_DI_LEAD;
        ISL_PACKET: begin
          mode_next  = M_DI_PKT;
          index_next = cnt_next;
          ready_next = (cnt_next == 5'd0);
        end
        ISL_GTRAIL: mode_next = M_DI_TRAIL;
        default: begin
          if ((cx_next < HA) && (cy_next < VA)) begin
            mode_next = M_VIDEO;
          end else if (!DVI && (line_after < VA) && (cx_next >= PRE_CX)) begin
            if (cx_next >= GUARD_CX) begin
              mode_next = M_VID_GRD;
            end else begin
              mode_next = M_VID_PRE;
              ctrl_next = 4'b1000;
            end
          end
        end
      endcase
    end
    hsync_next = ((cx_next >= HS_START) && (cx_next < HS_END)) ? SYNC_ON : !SYNC_ON;
    vsync_next = ((cy_next >= VS_START) && (cy_next < VS_END)) ? SYNC_ON : !SYNC_ON;
  end

  // State and output registers; reset aborts any island and disarms.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state_reg    <= ISL_IDLE;
      cnt_reg      <= 5'd0;
      slots_reg    <= 6'd0;
      armed_reg    <= 1'b0;
      cx           <= 16'd0;
      cy           <= 16'd0;
      mode         <= M_CTRL;
      ctrl         <= 4'b0000;
      hsync        <= !SYNC_ON;
      vsync        <= !SYNC_ON;
      packet_ready <= 1'b0;
      packet_index <= 5'd0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      slots_reg    <= slots_next;
      armed_reg    <= armed_next;
      cx           <= cx_next;
      cy           <= cy_next;
      mode         <= mode_next;
      ctrl         <= ctrl_next;
      hsync        <= hsync_next;
      vsync        <= vsync_next;
      packet_ready <= ready_next;
      packet_index <= index_next;
    end
  end

endmodule

// File: tb/tb_hdmi_period_sequencer.sv
// Self-checking bench: an HDMI instance and a DVI instance run side by side
// against a raster-level reference model.
module tb_hdmi_period_sequencer;

  localparam int HT = 120;
  localparam int VT = 8;

  logic clk = 1'b0;
  logic reset;
  logic pending;

  logic [2:0]  mode_a, mode_d;
  logic [3:0]  ctrl_a, ctrl_d;
  logic        hs_a, hs_d, vs_a, vs_d, rdy_a, rdy_d;
  logic [15:0] cx_a, cx_d, cy_a, cy_d;
  logic [4:0]  idx_a, idx_d;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_cx, m_cy, m_slots;
  bit m_armed, m_isl;

  always #5 clk = ~clk;

  hdmi_period_sequencer #(
    .H_ACTIVE(16), .H_TOTAL(HT), .V_ACTIVE(4), .V_TOTAL(VT),
    .H_SYNC_START(40), .H_SYNC_END(50), .V_SYNC_START(5), .V_SYNC_END(6),
    .SYNC_POL(1), .DVI_OUTPUT(0), .MAX_PACKETS(2)
  ) u_hdmi (
    .clk_pixel(clk), .reset(reset), .packet_pending(pending),
    .mode(mode_a), .ctrl(ctrl_a), .hsync(hs_a), .vsync(vs_a),
    .cx(cx_a), .cy(cy_a), .packet_ready(rdy_a), .packet_index(idx_a)
  );

  hdmi_period_sequencer #(
    .H_ACTIVE(16), .H_TOTAL(HT), .V_ACTIVE(4), .V_TOTAL(VT),
    .H_SYNC_START(40), .H_SYNC_END(50), .V_SYNC_START(5), .V_SYNC_END(6),
    .SYNC_POL(1), .DVI_OUTPUT(1), .MAX_PACKETS(2)
  ) u_dvi (
    .clk_pixel(clk), .reset(reset), .packet_pending(pending),
    .mode(mode_d), .ctrl(ctrl_d), .hsync(hs_d), .vsync(vs_d),
    .cx(cx_d), .cy(cy_d), .packet_ready(rdy_d), .packet_index(idx_d)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (model cx=%0d cy=%0d)", tag, obs, exp, m_cx, m_cy);
    end
  endtask

  task automatic model_reset();
    m_cx = 0; m_cy = 0; m_armed = 0; m_isl = 0; m_slots = 0;
  endtask

  // Expected HDMI outputs from raster position and island plan.
  task automatic expect_hdmi(output logic [2:0] em, output logic [3:0] ec,
                             output logic er, output logic [4:0] ei);
    int o, pkt_end;
    em = 3'd0; ec = 4'b0000; er = 1'b0; ei = 5'd0;
    o = m_cx - 20;
    pkt_end = 10 + 32 * m_slots;
    if (m_armed) begin
      if (m_isl && o >= 0 && o < pkt_end + 2) begin
        if (o < 8) begin
          em = 3'd4; ec = 4'b1010;
        end else if (o < 10) begin
          em = 3'd5;
        end else if (o < pkt_end) begin
          em = 3'd6; ei = 5'((o - 10) % 32); er = (((o - 10) % 32) == 0);
        end else begin
          em = 3'd7;
        end
      end else if (m_cx < 16 && m_cy < 4) begin
        em = 3'd3;
      end else if (((m_cy + 1) % VT) < 4 && m_cx >= HT - 10) begin
        if (m_cx <= HT - 3) begin
          em = 3'd1; ec = 4'b1000;
        end else begin
          em = 3'd2;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [2:0] em; logic [3:0] ec; logic er; logic [4:0] ei;
    logic hs_e, vs_e;
    expect_hdmi(em, ec, er, ei);
    hs_e = (m_cx >= 40 && m_cx < 50);
    vs_e = (m_cy == 5);
    check("hdmi_cx", cx_a, 16'(m_cx));
    check("hdmi_cy", cy_a, 16'(m_cy));
    check("hdmi_mode", 16'(mode_a), 16'(em));
    check("hdmi_ctrl", 16'(ctrl_a), 16'(ec));
    check("hdmi_hsync", 16'(hs_a), 16'(hs_e));
    check("hdmi_vsync", 16'(vs_a), 16'(vs_e));
    check("hdmi_ready", 16'(rdy_a), 16'(er));
    check("hdmi_index", 16'(idx_a), 16'(ei));
    check("dvi_cx", cx_d, 16'(m_cx));
    check("dvi_mode", 16'(mode_d), (m_armed && m_cx < 16 && m_cy < 4) ? 16'd3 : 16'd0);
    check("dvi_ctrl", 16'(ctrl_d), 16'd0);
    check("dvi_ready", 16'(rdy_d), 16'd0);
    check("dvi_hsync", 16'(hs_d), 16'(hs_e));
  endtask

  // Advance the model by one pixel given the pending level sampled this cycle.
  task automatic model_advance(input bit p);
    if (m_cx == 19 && m_armed && p) begin
      m_isl = 1; m_slots = 1;
    end else if (m_isl && (m_cx - 20) == 10 + 32 * m_slots - 1) begin
      if (p && m_slots < 2) m_slots++;
    end
    m_cx++;
    if (m_cx == HT) begin
      m_cx = 0; m_isl = 0; m_cy = (m_cy + 1) % VT;
    end
    if (m_cy == VT - 1 && m_cx == HT - 10) m_armed = 1;
  endtask

  // Called at a falling edge: check the presented cycle, drive, advance.
  task automatic step(input bit p);
    compare_all();
    pending = p;
    model_advance(p);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_to_line(input int target, input bit p);
    int n = 0;
    while (!(m_cx == 0 && m_cy == target) && n < 2000) begin
      step(p);
      n++;
    end
    if (n >= 2000) begin
      checks++; errors++;
      $error("FAIL run_to_line: observed timeout expected line %0d", target);
    end
  endtask

  initial begin
    reset = 1'b1;
    pending = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    $display("phase: reset state");
    compare_all();
    reset = 1'b0;

    $display("phase: unarmed frame then first video line, pending low");
    for (int i = 0; i < HT * VT + HT; i++) step(1'b0);

    $display("phase: pending held high, two packet slots");
    run_to_line(2, 1'b0);
    for (int i = 0; i < HT; i++) begin
      if (i == 20) check("di_pre_ctrl", 16'(ctrl_a), 16'b1010);
      if (i == 30 || i == 62) check("slot_ready", 16'(rdy_a), 16'd1);
      if (i == 94) check("trail_mode", 16'(mode_a), 16'd7);
      if (i == 96) check("ctrl_after", 16'(mode_a), 16'd0);
      step(1'b1);
    end

    $display("phase: pending dropped after first packet_ready");
    for (int i = 0; i < HT; i++) begin
      if (i == 62) check("single_trail", 16'(mode_a), 16'd7);
      if (i == 64) check("single_ctrl", 16'(mode_a), 16'd0);
      step(i <= 30);
    end

    $display("phase: random pending over two frames");
    for (int i = 0; i < 2 * HT * VT; i++) step(1'($urandom_range(0, 1)));

    $display("phase: reset mid-island");
    run_to_line(1, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1);
    check("pre_reset_mode", 16'(mode_a), 16'd6);
    reset = 1'b1;
    #1;
    check("async_mode", 16'(mode_a), 16'd0);
    check("async_ready", 16'(rdy_a), 16'd0);
    check("async_cx", cx_a, 16'd0);
    check("async_cy", cy_a, 16'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    reset = 1'b0;
    for (int i = 0; i < HT * VT + 2 * HT; i++) step(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
